// File: rtl/pc_trace_monitor.sv
// Retired-PC trace monitor. It checks that each PC is the previous PC plus the previous
// instruction length, unless the previous instruction was a control transfer, and optionally checks the PC against executable windows.
module pc_trace_monitor #(
  parameter int PC_W        = 16,
  parameter int LEN_W       = 2,
  parameter int NUM_REGIONS = 2,
  parameter int COUNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pc_valid_i,
  input  logic [PC_W-1:0]             pc_i,
  input  logic [LEN_W-1:0]            len_i,
  input  logic                        branch_i,
  input  logic [NUM_REGIONS-1:0]      region_en_i,
  input  logic [NUM_REGIONS*PC_W-1:0] region_lo_i,
  input  logic [NUM_REGIONS*PC_W-1:0] region_hi_i,
  input  logic                        region_chk_i,
  input  logic                        clr_i,
  output logic                        assert_valid,
  output logic                        fault_o,
  output logic [PC_W-1:0]             bad_pc_o,
  output logic [COUNT_W-1:0]          viol_cnt_o,
  output logic                        armed_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    prev_pc_q, prev_pc_d;
  logic [LEN_W-1:0]   prev_len_q, prev_len_d;
  logic               prev_br_q, prev_br_d;
  logic               assert_valid_q, assert_valid_d;
  logic               fault_q, fault_d;
  logic [PC_W-1:0]    bad_pc_q, bad_pc_d;
  logic [COUNT_W-1:0] viol_cnt_q, viol_cnt_d;
  logic               armed_q, armed_d;

  state_e             cur_state_s;
  logic               cur_fault_s;
  logic [PC_W-1:0]    cur_bad_pc_s;
  logic [COUNT_W-1:0] cur_cnt_s;
  logic [PC_W-1:0]    expect_pc_s;
  logic               seq_ok_s, reg_ok_s, len_ok_s, pass_s;

  // A window with lo > hi can never satisfy both compares, so it matches nothing.
  function automatic logic region_hit(
    input logic [PC_W-1:0]             pc,
    input logic [NUM_REGIONS-1:0]      en,
    input logic [NUM_REGIONS*PC_W-1:0] lo,
    input logic [NUM_REGIONS*PC_W-1:0] hi
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      hit = hit | (en[k] & (pc >= lo[k*PC_W +: PC_W]) & (pc <= hi[k*PC_W +: PC_W]));
    end
    return hit;
  endfunction

  // Check evaluation and next-state. A clear makes this sample look like the first one after IDLE.
  always_comb begin
    cur_state_s    = clr_i ? ST_IDLE : state_q;
    cur_fault_s    = clr_i ? 1'b0 : fault_q;
    cur_bad_pc_s   = clr_i ? {PC_W{1'b0}} : bad_pc_q;
    cur_cnt_s      = clr_i ? {COUNT_W{1'b0}} : viol_cnt_q;

    expect_pc_s    = prev_pc_q + PC_W'(prev_len_q);
    seq_ok_s       = (cur_state_s == ST_IDLE) | prev_br_q | (pc_i == expect_pc_s);
    reg_ok_s       = ~region_chk_i | region_hit(pc_i, region_en_i, region_lo_i, region_hi_i);
    len_ok_s       = (len_i != {LEN_W{1'b0}});
    pass_s         = seq_ok_s & reg_ok_s & len_ok_s;

    state_d        = cur_state_s;
    prev_pc_d      = prev_pc_q;
    prev_len_d     = prev_len_q;
    prev_br_d      = prev_br_q;
    assert_valid_d = 1'b0;
    fault_d        = cur_fault_s;
    bad_pc_d       = cur_bad_pc_s;
    viol_cnt_d     = cur_cnt_s;

    if (pc_valid_i) begin
      prev_pc_d  = pc_i;
      prev_len_d = len_i;
      prev_br_d  = branch_i;
      if (pass_s) begin
        case (cur_state_s)
          ST_IDLE:  begin state_d = ST_ARMED; assert_valid_d = 1'b1; end
          ST_ARMED: begin state_d = ST_ARMED; assert_valid_d = 1'b1; end
          ST_FAULT: begin state_d = ST_FAULT; assert_valid_d = 1'b0; end
          default:  begin state_d = ST_FAULT; assert_valid_d = 1'b0; end
        endcase
      end else begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
        if (!cur_fault_s) begin
          bad_pc_d = pc_i;
        end else begin
          bad_pc_d = cur_bad_pc_s;
        end
        if (cur_cnt_s == {COUNT_W{1'b1}}) begin
          viol_cnt_d = cur_cnt_s;
        end else begin
          viol_cnt_d = cur_cnt_s + COUNT_W'(1'b1);
        end
      end
    end else begin
      assert_valid_d = 1'b0;
    end

    armed_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      prev_pc_q      <= {PC_W{1'b0}};
      prev_len_q     <= {LEN_W{1'b0}};
      prev_br_q      <= 1'b0;
      assert_valid_q <= 1'b0;
      fault_q        <= 1'b0;
      bad_pc_q       <= {PC_W{1'b0}};
      viol_cnt_q     <= {COUNT_W{1'b0}};
      armed_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_pc_q      <= prev_pc_d;
      prev_len_q     <= prev_len_d;
      prev_br_q      <= prev_br_d;
      assert_valid_q <= assert_valid_d;
      fault_q        <= fault_d;
      bad_pc_q       <= bad_pc_d;
      viol_cnt_q     <= viol_cnt_d;
      armed_q        <= armed_d;
    end
  end

  assign assert_valid = assert_valid_q;
  assign fault_o      = fault_q;
  assign bad_pc_o     = bad_pc_q;
  assign viol_cnt_o   = viol_cnt_q;
  assign armed_o      = armed_q;

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Table-driven bench for pc_trace_monitor with a 2-bit counter so saturation is reachable.
// Expected outputs are queued as each vector is driven and popped one cycle later.
module tb_pc_trace_monitor;

  localparam int PC_W = 16;
  localparam int LEN_W = 2;
  localparam int NR = 2;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              pc_valid_i = 1'b0;
  logic [PC_W-1:0]   pc_i = '0;
  logic [LEN_W-1:0]  len_i = '0;
  logic              branch_i = 1'b0;
  logic [NR-1:0]     region_en_i = '0;
  logic [NR*PC_W-1:0] region_lo_i = '0;
  logic [NR*PC_W-1:0] region_hi_i = '0;
  logic              region_chk_i = 1'b0;
  logic              clr_i = 1'b0;
  logic              assert_valid;
  logic              fault_o;
  logic [PC_W-1:0]   bad_pc_o;
  logic [CW-1:0]     viol_cnt_o;
  logic              armed_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, clr, v;
    logic [15:0] pc;
    logic [1:0]  len;
    logic        br, chk;
    logic [1:0]  en;
    logic        av, flt;
    logic [15:0] bad;
    logic [1:0]  cnt;
    logic        arm;
  } vec_t;

  typedef struct {
    int          idx;
    logic        av, flt;
    logic [15:0] bad;
    logic [1:0]  cnt;
    logic        arm;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  pc_trace_monitor #(.PC_W(PC_W), .LEN_W(LEN_W), .NUM_REGIONS(NR), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pc_valid_i(pc_valid_i), .pc_i(pc_i), .len_i(len_i),
    .branch_i(branch_i), .region_en_i(region_en_i), .region_lo_i(region_lo_i),
    .region_hi_i(region_hi_i), .region_chk_i(region_chk_i), .clr_i(clr_i),
    .assert_valid(assert_valid), .fault_o(fault_o), .bad_pc_o(bad_pc_o),
    .viol_cnt_o(viol_cnt_o), .armed_o(armed_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic c, logic v, logic [15:0] pc, logic [1:0] len,
                              logic br, logic chk, logic [1:0] en, logic av, logic flt,
                              logic [15:0] bad, logic [1:0] cnt, logic arm);
    vec_t t;
    t.rst = r; t.clr = c; t.v = v; t.pc = pc; t.len = len; t.br = br; t.chk = chk; t.en = en;
    t.av = av; t.flt = flt; t.bad = bad; t.cnt = cnt; t.arm = arm;
    return t;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, req);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    exp_t e;
    rst = t.rst; clr_i = t.clr; pc_valid_i = t.v; pc_i = t.pc; len_i = t.len;
    branch_i = t.br; region_chk_i = t.chk; region_en_i = t.en;
    e.idx = idx; e.av = t.av; e.flt = t.flt; e.bad = t.bad; e.cnt = t.cnt; e.arm = t.arm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    cmp("assert_valid", e.idx, {31'd0, assert_valid}, {31'd0, e.av});
    cmp("fault_o",      e.idx, {31'd0, fault_o},      {31'd0, e.flt});
    cmp("bad_pc_o",     e.idx, {16'd0, bad_pc_o},     {16'd0, e.bad});
    cmp("viol_cnt_o",   e.idx, {30'd0, viol_cnt_o},   {30'd0, e.cnt});
    cmp("armed_o",      e.idx, {31'd0, armed_o},      {31'd0, e.arm});
  endtask

  initial begin
    // window0 = [0x0000,0x0FFF], window1 = [0x1000,0x1FFF]
    region_lo_i = {16'h1000, 16'h0000};
    region_hi_i = {16'h1FFF, 16'h0FFF};

    //               rst  clr  v    pc        len   br   chk  en     av   flt  bad       cnt   arm
    vecs.push_back(mk(1'b1,1'b0,1'b0,16'h0000,2'd0,1'b0,1'b0,2'b00, 1'b0,1'b0,16'h0000,2'd0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0000,2'd1,1'b0,1'b0,2'b00, 1'b1,1'b0,16'h0000,2'd0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0001,2'd2,1'b0,1'b0,2'b00, 1'b1,1'b0,16'h0000,2'd0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0003,2'd3,1'b0,1'b0,2'b00, 1'b1,1'b0,16'h0000,2'd0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0006,2'd1,1'b1,1'b0,2'b00, 1'b1,1'b0,16'h0000,2'd0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,2'd0,1'b0,1'b0,2'b00, 1'b0,1'b0,16'h0000,2'd0,1'b1));
    // wrap FFFE+2 -> 0000, then a sequential break
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'hFFFE,2'd2,1'b0,1'b0,2'b00, 1'b1,1'b0,16'h0000,2'd0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0000,2'd1,1'b0,1'b0,2'b00, 1'b1,1'b0,16'h0000,2'd0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0005,2'd1,1'b0,1'b0,2'b00, 1'b0,1'b1,16'h0005,2'd1,1'b1));
    // clear, then branch target test
    vecs.push_back(mk(1'b0,1'b1,1'b0,16'h0000,2'd0,1'b0,1'b0,2'b00, 1'b0,1'b0,16'h0000,2'd0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0100,2'd1,1'b1,1'b0,2'b00, 1'b1,1'b0,16'h0000,2'd0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h2000,2'd1,1'b0,1'b0,2'b00, 1'b1,1'b0,16'h0000,2'd0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h2005,2'd1,1'b0,1'b0,2'b00, 1'b0,1'b1,16'h2005,2'd1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h2006,2'd1,1'b0,1'b0,2'b00, 1'b0,1'b1,16'h2005,2'd1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h2009,2'd1,1'b0,1'b0,2'b00, 1'b0,1'b1,16'h2005,2'd2,1'b1));
    // region check from IDLE, then clear with simultaneous first sample
    vecs.push_back(mk(1'b1,1'b0,1'b0,16'h0000,2'd0,1'b0,1'b0,2'b00, 1'b0,1'b0,16'h0000,2'd0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h1000,2'd1,1'b0,1'b1,2'b01, 1'b0,1'b1,16'h1000,2'd1,1'b1));
    vecs.push_back(mk(1'b0,1'b1,1'b1,16'h1000,2'd1,1'b0,1'b1,2'b11, 1'b1,1'b0,16'h0000,2'd0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h1001,2'd2,1'b0,1'b1,2'b11, 1'b1,1'b0,16'h0000,2'd0,1'b1));
    // no window enabled with check on, then saturation
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h1003,2'd1,1'b0,1'b1,2'b00, 1'b0,1'b1,16'h1003,2'd1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0050,2'd1,1'b0,1'b0,2'b00, 1'b0,1'b1,16'h1003,2'd2,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0060,2'd1,1'b0,1'b0,2'b00, 1'b0,1'b1,16'h1003,2'd3,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0070,2'd1,1'b0,1'b0,2'b00, 1'b0,1'b1,16'h1003,2'd3,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0080,2'd1,1'b0,1'b0,2'b00, 1'b0,1'b1,16'h1003,2'd3,1'b1));
    vecs.push_back(mk(1'b0,1'b1,1'b1,16'h0040,2'd1,1'b0,1'b1,2'b01, 1'b1,1'b0,16'h0000,2'd0,1'b1));
    // zero length fails; a zero previous length predicts the same PC again
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0041,2'd0,1'b0,1'b0,2'b00, 1'b0,1'b1,16'h0041,2'd1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0041,2'd1,1'b0,1'b0,2'b00, 1'b0,1'b1,16'h0041,2'd1,1'b1));
    // reset dominates a same-cycle clear and failing sample
    vecs.push_back(mk(1'b1,1'b1,1'b1,16'hDEAD,2'd0,1'b0,1'b1,2'b00, 1'b0,1'b0,16'h0000,2'd0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0123,2'd1,1'b0,1'b0,2'b00, 1'b1,1'b0,16'h0000,2'd0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0124,2'd1,1'b1,1'b0,2'b00, 1'b1,1'b0,16'h0000,2'd0,1'b1));
    // inclusive upper bound, then one past it
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0FFF,2'd1,1'b0,1'b1,2'b01, 1'b1,1'b0,16'h0000,2'd0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,16'h1000,2'd1,1'b0,1'b1,2'b01, 1'b0,1'b1,16'h1000,2'd1,1'b1));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Inverted window matches nothing; then reprogram it between samples.
    region_lo_i[31:16] = 16'h3000;
    region_hi_i[31:16] = 16'h2000;
    apply(mk(1'b1,1'b0,1'b0,16'h0000,2'd0,1'b0,1'b0,2'b00, 1'b0,1'b0,16'h0000,2'd0,1'b0), 100);
    apply(mk(1'b0,1'b0,1'b1,16'h2800,2'd1,1'b0,1'b1,2'b10, 1'b0,1'b1,16'h2800,2'd1,1'b1), 101);
    region_lo_i[31:16] = 16'h2000;
    region_hi_i[31:16] = 16'h3000;
    apply(mk(1'b0,1'b1,1'b1,16'h2800,2'd1,1'b0,1'b1,2'b10, 1'b1,1'b0,16'h0000,2'd0,1'b1), 102);
    apply(mk(1'b0,1'b0,1'b1,16'h2801,2'd1,1'b0,1'b1,2'b10, 1'b1,1'b0,16'h0000,2'd0,1'b1), 103);
    apply(mk(1'b0,1'b0,1'b0,16'h0000,2'd0,1'b0,1'b0,2'b00, 1'b0,1'b0,16'h0000,2'd0,1'b1), 104);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
